req_ack_responder: RTL and testbench

- Target-side responder for the single-bit req/ack handshake.
- Samples a req with its payload and answers exactly one cycle later: ack if the payload was accepted, nack if it was refused.
- Accepted payloads are buffered in a small FIFO and drained downstream over a valid/ready interface.
- Guarantees the handshake property "req |=> ack" (while rst is low) whenever the FIFO has room.

---
 rtl/req_ack_responder_if.sv | 35 +++
 rtl/req_ack_responder.sv | 99 +++++++++
 tb/tb_req_ack_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/req_ack_responder_if.sv
// rtl/req_ack_responder_if.sv - req/ack request side and valid/ready drain side of the responder
//
// Signals:
//   req, req_data        request strobe and payload (master -> slave)
//   ack, nack            registered response, one cycle after req (slave -> master)
//   out_valid, out_data  FIFO head presentation (slave -> master)
//   out_ready            downstream consumer ready (master -> slave)
//   level                FIFO occupancy 0..DEPTH (slave -> master)
//   ovf_err              sticky refused-request flag (slave -> master)
interface req_ack_responder_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          req;
    logic [DW-1:0] req_data;
    logic          ack;
    logic          nack;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          ovf_err;

    modport master (
        output req, req_data, out_ready,
        input  ack, nack, out_valid, out_data, level, ovf_err
    );

    modport slave (
        input  req, req_data, out_ready,
        output ack, nack, out_valid, out_data, level, ovf_err
    );
endinterface

// File: rtl/req_ack_responder.sv
// rtl/req_ack_responder.sv - target-side req/ack responder buffering accepted payloads in a FIFO
//
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  slave side of req_ack_responder_if: req/req_data in, ack/nack out,
//        out_valid/out_data/out_ready drain, level and sticky ovf_err status
module req_ack_responder #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    req_ack_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;
    logic          ovf_q, ovf_d;

    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign pop   = !empty && bus.out_ready;
    // A full FIFO can still take a request when the head leaves on the same edge.
    assign push  = bus.req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ack_d    = 1'b0;
        nack_d   = 1'b0;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (bus.req) begin
            ack_d  = push;
            nack_d = !push;
            if (!push) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= bus.req_data;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.nack      = nack_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.level     = level_q;
    assign bus.ovf_err   = ovf_q;
endmodule

// File: tb/tb_req_ack_responder.sv
// tb/tb_req_ack_responder.sv - vector table plus data scoreboard for req_ack_responder
module tb_req_ack_responder;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    req_ack_responder_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    req_ack_responder #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic          ready;
        logic          ack;
        logic          nack;
        int            level;
        logic          ovf;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sb[$];
    int            prev_level;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic [DW-1:0] d, input logic rdy,
                                input logic a, input logic n, input int lv, input logic o);
        vec_t v;
        v.req = r; v.data = d; v.ready = rdy;
        v.ack = a; v.nack = n; v.level = lv; v.ovf = o;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.req       = v.req;
        bus.req_data  = v.data;
        bus.out_ready = v.ready;
        if (prev_level > 0 && v.ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
            end
        end
        if (v.ack) sb.push_back(v.data);
        @(posedge clk);
        #1;
        chk("ack", 32'(bus.ack), 32'(v.ack));
        chk("nack", 32'(bus.nack), 32'(v.nack));
        chk("level", 32'(bus.level), 32'(v.level));
        chk("out_valid", 32'(bus.out_valid), 32'(v.level != 0));
        chk("ovf_err", 32'(bus.ovf_err), 32'(v.ovf));
        prev_level = v.level;
    endtask

    property p_resp;
        @(posedge clk) disable iff (rst) bus.req |=> (bus.ack ^ bus.nack);
    endproperty
    property p_excl;
        @(posedge clk) disable iff (rst) !(bus.ack && bus.nack);
    endproperty
    property p_room;
        @(posedge clk) disable iff (rst) (bus.level < DEPTH && bus.req) |=> bus.ack;
    endproperty

    a_resp: assert property (p_resp) else begin
        bad++; $display("FAIL assert_resp actual=no_response required=ack_xor_nack at %0t", $time);
    end
    a_excl: assert property (p_excl) else begin
        bad++; $display("FAIL assert_excl actual=both required=not_both at %0t", $time);
    end
    a_room: assert property (p_room) else begin
        bad++; $display("FAIL assert_room actual=no_ack required=ack at %0t", $time);
    end

    initial begin
        bus.req       = 1'b0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        prev_level    = 0;

        // Single request, then drain
        add(1, 8'hA5, 0, 1, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        // Overflow with consumer stalled
        add(1, 8'h01, 0, 1, 0, 1, 0);
        add(1, 8'h02, 0, 1, 0, 2, 0);
        add(1, 8'h03, 0, 1, 0, 3, 0);
        add(1, 8'h04, 0, 1, 0, 4, 0);
        add(1, 8'h05, 0, 0, 1, 4, 1);
        add(1, 8'h06, 0, 0, 1, 4, 1);
        add(0, 8'h00, 0, 0, 0, 4, 1);
        // Full with simultaneous pop and push
        add(1, 8'h07, 1, 1, 0, 4, 1);
        add(0, 8'h00, 1, 0, 0, 3, 1);
        add(0, 8'h00, 1, 0, 0, 2, 1);
        add(0, 8'h00, 1, 0, 0, 1, 1);
        add(0, 8'h00, 1, 0, 0, 0, 1);
        // Streaming back-to-back with pointer wrap
        for (int i = 0; i < 8; i++) begin
            add(1, 8'(8'h10 + i), 1, 1, 0, 1, 1);
        end
        add(0, 8'h00, 1, 0, 0, 0, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_nack", 32'(bus.nack), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_ovf", 32'(bus.ovf_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Request accepted, then reset lands before its response is consumed
        @(negedge clk);
        bus.req       = 1'b1;
        bus.req_data  = 8'h55;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(bus.ack), 32'd0);
        chk("mid_rst_level", 32'(bus.level), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf_err), 32'd0);
        @(negedge clk);
        bus.req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("hold_rst_ack", 32'(bus.ack), 32'd0);
            chk("hold_rst_nack", 32'(bus.nack), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ack", 32'(bus.ack), 32'd0);
        chk("post_rst_level", 32'(bus.level), 32'd0);
        sb.delete();
        prev_level = 0;

        vecs.delete();
        add(1, 8'hAA, 0, 1, 0, 1, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
